// File: rtl/button_debouncer.sv
// Debouncer for the active-low board push-button: 2-FF synchronizer, debounce FSM,
// registered level plus one-cycle press/release/long-press strobes.
module button_debouncer #(
    parameter int unsigned CNT_MAX  = 269_999,
    parameter int unsigned LONG_MAX = 26_999_999
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DCNT_W = (CNT_MAX  > 0) ? $clog2(CNT_MAX + 1)  : 1;
    localparam int unsigned LCNT_W = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(CNT_MAX);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_MAX);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              s;

    // Synchronizer idles at 1 (released) so reset never looks like a press.
    always_comb begin
        sync1_d = btn_n_in;
        sync2_d = sync1_q;
        s       = ~sync2_q;
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end

            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d     = PRESSED;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                    press_d     = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end

            // long_done keeps the long strobe to once per debounced press,
            // even across release bounces that return here.
            PRESSED: begin
                if (lcnt_q == LCNT_LAST && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (lcnt_q != LCNT_LAST) begin
                    lcnt_d = lcnt_q + LCNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule
